instruction_decoder: RTL and testbench
======================================

INSTRUCTION_DECODER -- requirements
Module: instruction_decoder

Interface
REQ-001 The block SHALL have the following ports, one per line as name, direction, width, meaning:
- clk  in  1  single system clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- pm_data  in  8  instruction word read from program memory at the program sequencer's pm_addr.
- alu_zero  in  1  ALU result-is-zero, valid in the cycle an ALU instruction is decoded.
- ir  out  8  instruction register.
- jmp  out  1  unconditional jump request to the program sequencer.
- jmp_nz  out  1  conditional jump request (taken when dont_jmp=0).
- jmp_addr  out  4  jump target nibble, always equal to ir[3:0].
- dont_jmp  out  1  registered zero flag, fed to the sequencer.
- reg_en  out  8  one-hot register load enables: bit0 x0, 1 x1, 2 y0, 3 y1, 4 r, 5 m, 6 i, 7 o_reg.
- src_sel  out  4  data-bus source: 0-7 register index (same order as reg_en), 8 immediate ir[3:0].
- alu_func  out  3  ALU operation code.
- valid  out  1  decoded instruction is live.

Function
REQ-002 ir SHALL load pm_data on every rising clk edge when reset_n=1.
REQ-003 valid SHALL be 0 for exactly the first clk edge after reset_n rises, and 1 from the second edge onward (one-cycle pipeline bubble).
REQ-004 All decode outputs (jmp, jmp_nz, reg_en, src_sel, alu_func) SHALL be combinational functions of ir and valid, with no added latency.
REQ-005 While valid=0: jmp=0, jmp_nz=0, reg_en=8'h00, src_sel=4'h0, alu_func=3'h0.
REQ-006 Load immediate, ir[7]=0: reg_en one-hot at index ir[6:4], src_sel=4'h8.
REQ-007 Move, ir[7:6]=2'b10: reg_en one-hot at index ir[5:3], src_sel={1'b0,ir[2:0]}.
REQ-008 Move with ir[5:3]==ir[2:0] SHALL be a NOP: reg_en=8'h00, src_sel=4'h0.
REQ-009 ALU, ir[7:5]=3'b110: reg_en=8'h10 (r), alu_func=ir[4:2], src_sel=4'h0.
REQ-010 Jump, ir[7:4]=4'b1110: jmp=1, reg_en=8'h00.
REQ-011 Conditional jump, ir[7:4]=4'b1111: jmp_nz=1, reg_en=8'h00.
REQ-012 jmp and jmp_nz SHALL never be 1 in the same cycle; reg_en SHALL always be zero or one-hot.
REQ-013 alu_func SHALL be 3'h0 for every non-ALU instruction.
REQ-014 Zero flag: on a rising edge where valid=1 and ir is an ALU instruction, the flag SHALL load alu_zero; otherwise it SHALL hold.
REQ-015 dont_jmp SHALL equal the zero flag register directly, with no combinational path from alu_zero.
REQ-016 A jmp_nz immediately following an ALU instruction SHALL see the flag produced by that ALU instruction.
REQ-017 jmp_addr SHALL equal ir[3:0] regardless of instruction type or valid.

Reset
REQ-018 On reset_n=0, outputs SHALL update immediately without waiting for clk: ir=8'h00, valid=0, zero flag=0 (dont_jmp=0); all decode outputs then follow REQ-005.
REQ-019 Reset asserted mid-instruction SHALL clear valid and the zero flag regardless of the current ir.
REQ-020 Only ir, valid and the zero flag SHALL hold state; no other storage is permitted.

Verification
REQ-021 The bench SHALL cover the following directed scenarios:
- Reset release: reset_n 0->1, pm_data=8'h35 -> edge 1: ir=8'h35, valid=0, reg_en=0; edge 2: valid=1, and reg_en=8'h08 once ir holds 8'h35.
- Load/move: ir=8'h35 -> reg_en=8'h08, src_sel=8; ir=8'h8A -> reg_en=8'h02, src_sel=2; ir=8'h92 -> reg_en=0 (NOP).
- ALU then jnz: ir=8'hC8, alu_zero=1 -> reg_en=8'h10, alu_func=2, dont_jmp=1 next cycle; ir=8'hF7 -> jmp_nz=1, jmp_addr=7, dont_jmp=1.
- Flag hold: ALU with alu_zero=0, then ir=8'h35 with alu_zero=1 -> dont_jmp stays 0.
- Jump: ir=8'hEA -> jmp=1, jmp_nz=0, jmp_addr=4'hA, reg_en=0.
- Async reset: reset_n pulsed low mid-cycle with zero flag=1 -> dont_jmp=0 and valid=0 before the next clk edge.

Source files
------------

// File: rtl/instruction_decoder.sv
// Instruction register plus combinational decoder for a small accumulator-style core.
// Holds ir, a one-cycle startup bubble on valid, and the ALU zero flag used by conditional jumps.
module instruction_decoder (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] pm_data,
  input  logic       alu_zero,
  output logic [7:0] ir,
  output logic       jmp,
  output logic       jmp_nz,
  output logic [3:0] jmp_addr,
  output logic       dont_jmp,
  output logic [7:0] reg_en,
  output logic [3:0] src_sel,
  output logic [2:0] alu_func,
  output logic       valid
);

  localparam int unsigned IrW    = 8;
  localparam int unsigned RegW   = 8;
  localparam int unsigned SelW   = 4;
  localparam int unsigned FuncW  = 3;
  localparam int unsigned VldW   = 2;

  localparam logic [SelW-1:0] SrcImm  = SelW'(8);
  localparam logic [RegW-1:0] RegEnR  = RegW'(8'h10);

  logic [IrW-1:0]  ir_q, ir_d;
  logic [VldW-1:0] valid_q, valid_d;
  logic            zero_q, zero_d;
  logic            is_alu;

  assign is_alu = (ir_q[7:5] == 3'b110);

  // valid is a two-stage shift of 1s so the first fetched word is never executed
  always_comb begin
    ir_d    = pm_data;
    valid_d = {valid_q[0], 1'b1};
    zero_d  = zero_q;
    if (valid_q[VldW-1] && is_alu) begin
      zero_d = alu_zero;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ir_q    <= '0;
      valid_q <= '0;
      zero_q  <= 1'b0;
    end else begin
      ir_q    <= ir_d;
      valid_q <= valid_d;
      zero_q  <= zero_d;
    end
  end

  // Decode: opcode prefix picks load-immediate, move, ALU, jump or conditional jump
  always_comb begin
    jmp      = 1'b0;
    jmp_nz   = 1'b0;
    reg_en   = '0;
    src_sel  = '0;
    alu_func = '0;
    if (valid_q[VldW-1]) begin
      if (!ir_q[7]) begin
        reg_en  = RegW'(1) << ir_q[6:4];
        src_sel = SrcImm;
      end else if (!ir_q[6]) begin
        if (ir_q[5:3] != ir_q[2:0]) begin
          reg_en  = RegW'(1) << ir_q[5:3];
          src_sel = {1'b0, ir_q[2:0]};
        end
      end else if (!ir_q[5]) begin
        reg_en   = RegEnR;
        alu_func = FuncW'(ir_q[4:2]);
      end else if (!ir_q[4]) begin
        jmp = 1'b1;
      end else begin
        jmp_nz = 1'b1;
      end
    end
  end

  assign ir       = ir_q;
  assign valid    = valid_q[VldW-1];
  assign dont_jmp = zero_q;
  assign jmp_addr = ir_q[3:0];

endmodule

// File: tb/tb_instruction_decoder.sv
// Scoreboard bench for instruction_decoder: a reference model predicts every output after
// each clock edge; predictions are queued at drive time and compared once the edge has passed.
module tb_instruction_decoder;

  logic       clk;
  logic       reset_n;
  logic [7:0] pm_data;
  logic       alu_zero;
  logic [7:0] ir;
  logic       jmp;
  logic       jmp_nz;
  logic [3:0] jmp_addr;
  logic       dont_jmp;
  logic [7:0] reg_en;
  logic [3:0] src_sel;
  logic [2:0] alu_func;
  logic       valid;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] ir;
    logic       valid;
    logic       jmp;
    logic       jmp_nz;
    logic [3:0] jmp_addr;
    logic       dont_jmp;
    logic [7:0] reg_en;
    logic [3:0] src_sel;
    logic [2:0] alu_func;
  } exp_t;

  exp_t sb_q[$];

  // model state, mirrors what the outputs should show after the most recent edge
  logic [7:0] m_ir;
  logic       m_valid;
  logic       m_zero;
  int         m_edges;

  instruction_decoder dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .pm_data  (pm_data),
    .alu_zero (alu_zero),
    .ir       (ir),
    .jmp      (jmp),
    .jmp_nz   (jmp_nz),
    .jmp_addr (jmp_addr),
    .dont_jmp (dont_jmp),
    .reg_en   (reg_en),
    .src_sel  (src_sel),
    .alu_func (alu_func),
    .valid    (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got=0x%0h want=0x%0h (t=%0t ir=0x%02h)", tag, got, want, $time, ir);
    end
  endtask

  function automatic exp_t predict(input logic [7:0] i, input logic v, input logic z);
    exp_t e;
    e.ir       = i;
    e.valid    = v;
    e.jmp      = 1'b0;
    e.jmp_nz   = 1'b0;
    e.jmp_addr = i[3:0];
    e.dont_jmp = z;
    e.reg_en   = 8'h00;
    e.src_sel  = 4'h0;
    e.alu_func = 3'h0;
    if (v) begin
      casez (i)
        8'b0???????: begin
          e.reg_en  = 8'h01 << i[6:4];
          e.src_sel = 4'h8;
        end
        8'b10??????: begin
          if (i[5:3] != i[2:0]) begin
            e.reg_en  = 8'h01 << i[5:3];
            e.src_sel = {1'b0, i[2:0]};
          end
        end
        8'b110?????: begin
          e.reg_en   = 8'h10;
          e.alu_func = i[4:2];
        end
        8'b1110????: e.jmp    = 1'b1;
        default:     e.jmp_nz = 1'b1;
      endcase
    end
    return e;
  endfunction

  task automatic compare_out(input string tag, input exp_t e);
    check_eq({tag, ".ir"},       32'(ir),       32'(e.ir));
    check_eq({tag, ".valid"},    32'(valid),    32'(e.valid));
    check_eq({tag, ".jmp"},      32'(jmp),      32'(e.jmp));
    check_eq({tag, ".jmp_nz"},   32'(jmp_nz),   32'(e.jmp_nz));
    check_eq({tag, ".jmp_addr"}, 32'(jmp_addr), 32'(e.jmp_addr));
    check_eq({tag, ".dont_jmp"}, 32'(dont_jmp), 32'(e.dont_jmp));
    check_eq({tag, ".reg_en"},   32'(reg_en),   32'(e.reg_en));
    check_eq({tag, ".src_sel"},  32'(src_sel),  32'(e.src_sel));
    check_eq({tag, ".alu_func"}, 32'(alu_func), 32'(e.alu_func));
    check_eq({tag, ".excl"},     32'(jmp & jmp_nz), 32'(0));
    check_eq({tag, ".onehot0"},  32'($onehot0(reg_en)), 32'(1));
  endtask

  // Called at a negedge: drive the next fetch word and the zero result for the
  // currently decoded instruction, predict post-edge outputs, then compare after the edge.
  task automatic step(input string tag, input logic [7:0] instr, input logic az);
    exp_t e;
    pm_data  = instr;
    alu_zero = az;
    if (m_valid && (m_ir[7:5] == 3'b110)) m_zero = az;
    m_ir = instr;
    m_edges++;
    m_valid = (m_edges >= 2);
    sb_q.push_back(predict(m_ir, m_valid, m_zero));
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check_eq({tag, ".sb_empty"}, 32'(1), 32'(0));
    end else begin
      e = sb_q.pop_front();
      compare_out(tag, e);
    end
    @(negedge clk);
  endtask

  task automatic model_reset();
    m_ir    = 8'h00;
    m_valid = 1'b0;
    m_zero  = 1'b0;
    m_edges = 0;
  endtask

  initial begin
    reset_n  = 1'b0;
    pm_data  = 8'h00;
    alu_zero = 1'b0;
    model_reset();
    #2;
    compare_out("rst_async", predict(8'h00, 1'b0, 1'b0));
    @(negedge clk);
    @(negedge clk);
    compare_out("rst_hold", predict(8'h00, 1'b0, 1'b0));

    // reset release with the first instruction word on the bus
    reset_n = 1'b1;
    step("rel_e1", 8'h35, 1'b0);
    check_eq("rel_e1_valid", 32'(valid), 32'(0));
    step("rel_e2", 8'h35, 1'b0);
    check_eq("rel_e2_reg_en", 32'(reg_en), 32'(8'h08));

    // load / move / move-NOP
    step("mov_8a", 8'h8A, 1'b0);
    check_eq("mov_8a_src", 32'(src_sel), 32'(2));
    step("nop_92", 8'h92, 1'b0);
    check_eq("nop_92_reg_en", 32'(reg_en), 32'(0));

    // ALU sets the flag, following jnz sees it
    step("alu_c8", 8'hC8, 1'b0);
    check_eq("alu_c8_func", 32'(alu_func), 32'(2));
    step("jnz_f7", 8'hF7, 1'b1);
    check_eq("jnz_f7_dont_jmp", 32'(dont_jmp), 32'(1));
    check_eq("jnz_f7_addr", 32'(jmp_addr), 32'(7));

    // flag hold: ALU clears it, non-ALU with alu_zero=1 must not touch it
    step("hold_alu", 8'hC4, 1'b0);
    step("hold_ld", 8'h35, 1'b0);
    check_eq("hold_ld_dont_jmp", 32'(dont_jmp), 32'(0));
    step("hold_next", 8'hEA, 1'b1);
    check_eq("hold_next_dont_jmp", 32'(dont_jmp), 32'(0));
    check_eq("jmp_ea_jmp", 32'(jmp), 32'(1));
    check_eq("jmp_ea_addr", 32'(jmp_addr), 32'(4'hA));

    // set the flag again, then pulse reset between edges
    step("pre_alu", 8'hC8, 1'b0);
    step("pre_jnz", 8'hF7, 1'b1);
    check_eq("pre_rst_dont_jmp", 32'(dont_jmp), 32'(1));
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    compare_out("rst_mid", predict(8'h00, 1'b0, 1'b0));
    @(negedge clk);
    reset_n = 1'b1;

    // random instruction stream with random zero results
    for (int k = 0; k < 80; k++) begin
      step("rand", 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    end

    check_eq("sb_drained", 32'(sb_q.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
